// File: rtl/wb_io_responder.sv
// Wishbone B3 IO slave terminating the CPU IO bus: POST-code port, debug console
// byte FIFO with status/control port, and deterministic replies for unmapped ports.
module wb_io_responder #(
    parameter int unsigned WAIT_STATES  = 0,
    parameter int unsigned FIFO_DEPTH   = 16,
    parameter bit          ERR_UNMAPPED = 1'b0
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [15:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic [2:0]  wb_cti_i,
    input  logic [1:0]  wb_bte_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    output logic [7:0]  post_code_o,
    output logic [7:0]  con_data_o,
    output logic        con_valid_o,
    input  logic        con_ready_i,
    output logic        con_overflow_o
);

    localparam int unsigned AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [4:0]  FULL_COUNT = 5'(FIFO_DEPTH);
    localparam logic [3:0]  WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [13:0] WORD_POST  = 14'h0020;
    localparam logic [13:0] WORD_CON   = 14'h003A;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [13:0] lat_word;
    logic        lat_we;
    logic [3:0]  lat_sel;
    logic [7:0]  lat_post;
    logic [7:0]  lat_con;
    logic        lat_clr;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [4:0]    count;
    logic          overflow;

    logic [13:0] req_word;
    logic        req_we;
    logic [3:0]  req_sel;
    logic [7:0]  req_post;
    logic [7:0]  req_con;
    logic        req_clr;
    logic        commit;
    logic        hit_post;
    logic        hit_con;
    logic        unmapped;
    logic        resp_err;
    logic [31:0] rdata;
    logic        wr_post;
    logic        push_req;
    logic        clr_ovf;
    logic        pop;
    logic        full;
    logic        push_ok;
    logic        drop;
    logic        unused_bits;

    assign unused_bits = ^{wb_cti_i, wb_bte_i, wb_adr_i[1:0], wb_dat_i[31:24], wb_dat_i[22:16]};

    // With no wait states the request commits on its sampling edge, so decode the live bus;
    // otherwise decode the copy latched when the request was accepted.
    always_comb begin
        req_word = lat_word;
        req_we   = lat_we;
        req_sel  = lat_sel;
        req_post = lat_post;
        req_con  = lat_con;
        req_clr  = lat_clr;
        if (state == S_IDLE) begin
            req_word = wb_adr_i[15:2];
            req_we   = wb_we_i;
            req_sel  = wb_sel_i;
            req_post = wb_dat_i[7:0];
            req_con  = wb_dat_i[15:8];
            req_clr  = wb_dat_i[23];
        end
    end

    always_comb begin
        commit = 1'b0;
        case (state)
            S_IDLE:  commit = (WAIT_STATES == 0) && wb_cyc_i && wb_stb_i;
            S_WAIT:  commit = wb_cyc_i && (wait_cnt == '0);
            default: commit = 1'b0;
        endcase
    end

    assign hit_post = (req_word == WORD_POST);
    assign hit_con  = (req_word == WORD_CON);
    assign unmapped = !hit_post && !hit_con;
    assign resp_err = unmapped && ERR_UNMAPPED && (req_sel != '0);

    assign wr_post  = commit && req_we && hit_post && req_sel[0];
    assign push_req = commit && req_we && hit_con && req_sel[1];
    assign clr_ovf  = commit && req_we && hit_con && req_sel[2] && req_clr;

    assign con_valid_o    = (count != '0);
    assign con_data_o     = con_valid_o ? fifo_mem[rptr] : '0;
    assign con_overflow_o = overflow;
    assign wb_rty_o       = 1'b0;

    assign pop     = con_valid_o && con_ready_i;
    assign full    = (count == FULL_COUNT);
    assign push_ok = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;

    always_comb begin
        rdata = '0;
        if (unmapped) begin
            rdata = '1;
        end else if (hit_post) begin
            rdata[7:0] = req_sel[0] ? post_code_o : 8'h00;
        end else begin
            rdata[15:8]  = req_sel[1] ? 8'hE9 : 8'h00;
            rdata[23:16] = req_sel[2] ? {overflow, 2'b00, count} : 8'h00;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            lat_word <= '0;
            lat_we   <= 1'b0;
            lat_sel  <= '0;
            lat_post <= '0;
            lat_con  <= '0;
            lat_clr  <= 1'b0;
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            wb_dat_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        lat_word <= wb_adr_i[15:2];
                        lat_we   <= wb_we_i;
                        lat_sel  <= wb_sel_i;
                        lat_post <= wb_dat_i[7:0];
                        lat_con  <= wb_dat_i[15:8];
                        lat_clr  <= wb_dat_i[23];
                        if (WAIT_STATES == 0) begin
                            state <= S_RESP;
                        end else begin
                            state    <= S_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                S_WAIT: begin
                    if (!wb_cyc_i) begin
                        state <= S_IDLE;
                    end else if (wait_cnt == '0) begin
                        state <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
            wb_ack_o <= commit && !resp_err;
            wb_err_o <= commit && resp_err;
            wb_dat_o <= (commit && !resp_err) ? rdata : '0;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            post_code_o <= '0;
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            overflow    <= 1'b0;
        end else begin
            if (wr_post) begin
                post_code_o <= req_post;
            end
            if (push_ok) begin
                wptr <= wptr + PTR_ONE;
            end
            if (pop) begin
                rptr <= rptr + PTR_ONE;
            end
            case ({push_ok, pop})
                2'b10:   count <= count + 5'd1;
                2'b01:   count <= count - 5'd1;
                default: count <= count;
            endcase
            // Clear wins when one access both drops a byte and clears the flag.
            if (clr_ovf) begin
                overflow <= 1'b0;
            end else if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (push_ok) begin
            fifo_mem[wptr] <= req_con;
        end
    end

endmodule

// File: tb/tb_wb_io_responder.sv
// Directed bench for wb_io_responder: three instances cover zero, three and five
// wait states and both unmapped-port policies.
module tb_wb_io_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        stb;
    logic [2:0]  cyc;
    logic        con_ready;
    logic [2:0]  cti = 3'b000;
    logic [1:0]  bte = 2'b00;

    logic [2:0]       ack;
    logic [2:0]       err;
    logic [2:0]       rty;
    logic [2:0]       valid;
    logic [2:0]       ovf;
    logic [2:0][31:0] rdat;
    logic [2:0][7:0]  post;
    logic [2:0][7:0]  cdata;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_io_responder #(.WAIT_STATES(0), .FIFO_DEPTH(16), .ERR_UNMAPPED(1'b0)) u_ws0 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc[0]), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_dat_o(rdat[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]), .wb_rty_o(rty[0]),
        .post_code_o(post[0]), .con_data_o(cdata[0]), .con_valid_o(valid[0]),
        .con_ready_i(con_ready), .con_overflow_o(ovf[0]));

    wb_io_responder #(.WAIT_STATES(3), .FIFO_DEPTH(16), .ERR_UNMAPPED(1'b1)) u_ws3 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc[1]), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_dat_o(rdat[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]), .wb_rty_o(rty[1]),
        .post_code_o(post[1]), .con_data_o(cdata[1]), .con_valid_o(valid[1]),
        .con_ready_i(con_ready), .con_overflow_o(ovf[1]));

    wb_io_responder #(.WAIT_STATES(5), .FIFO_DEPTH(16), .ERR_UNMAPPED(1'b0)) u_ws5 (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(adr), .wb_dat_i(dat), .wb_sel_i(sel),
        .wb_we_i(we), .wb_cyc_i(cyc[2]), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_dat_o(rdat[2]), .wb_ack_o(ack[2]), .wb_err_o(err[2]), .wb_rty_o(rty[2]),
        .post_code_o(post[2]), .con_data_o(cdata[2]), .con_valid_o(valid[2]),
        .con_ready_i(con_ready), .con_overflow_o(ovf[2]));

    // Classic cycle on instance d; lat counts cycles from the request edge to the
    // cycle in which ack/err is seen (40 means no response arrived).
    task automatic xfer(input int d, input logic [15:0] a, input logic w, input logic [3:0] s,
                        input logic [31:0] dv, output logic [31:0] rd, output logic ga,
                        output logic ge, output int lat);
        @(negedge clk);
        adr = a; we = w; sel = s; dat = dv; stb = 1'b1; cyc[d] = 1'b1;
        @(posedge clk);
        lat = 0; ga = 1'b0; ge = 1'b0; rd = '0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (ack[d] || err[d]) begin
                ga = ack[d]; ge = err[d]; rd = rdat[d];
                break;
            end
        end
        cyc[d] = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cyc = '0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0;
        con_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({ack, err, rty} !== 9'h0) begin n_bad++; $display("FAIL reset_resp: got %h expected 000", {ack, err, rty}); end
        n_cmp++; if (rdat !== 96'h0) begin n_bad++; $display("FAIL reset_dat: got %h expected 0", rdat); end
        n_cmp++; if (post !== 24'h0) begin n_bad++; $display("FAIL reset_post: got %h expected 000000", post); end
        n_cmp++; if ({valid, ovf} !== 6'h0) begin n_bad++; $display("FAIL reset_valid_ovf: got %h expected 00", {valid, ovf}); end
        n_cmp++; if (cdata !== 24'h0) begin n_bad++; $display("FAIL reset_con_data: got %h expected 000000", cdata); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_post();
        logic [31:0] rd; logic ga, ge; int lat;
        xfer(0, 16'h0080, 1'b1, 4'b0001, 32'h0000005A, rd, ga, ge, lat);
        n_cmp++; if (!(ga === 1'b1 && lat == 1)) begin n_bad++; $display("FAIL post_wr_latency: got ack=%b lat=%0d expected ack=1 lat=1", ga, lat); end
        n_cmp++; if (post[0] !== 8'h5A) begin n_bad++; $display("FAIL post_wr_value: got %h expected 5a", post[0]); end
        @(negedge clk);
        n_cmp++; if (ack[0] !== 1'b0) begin n_bad++; $display("FAIL post_ack_width: got %b expected 0", ack[0]); end
        xfer(0, 16'h0080, 1'b0, 4'b0001, 32'h0, rd, ga, ge, lat);
        n_cmp++; if (rd !== 32'h0000005A || lat != 1) begin n_bad++; $display("FAIL post_rd: got %h lat=%0d expected 0000005a lat=1", rd, lat); end
        xfer(0, 16'h0080, 1'b1, 4'b0000, 32'h000000FF, rd, ga, ge, lat);
        n_cmp++; if (ga !== 1'b1 || post[0] !== 8'h5A) begin n_bad++; $display("FAIL sel_zero: got ack=%b post=%h expected ack=1 post=5a", ga, post[0]); end
    endtask

    task automatic test_wait_read();
        logic [31:0] rd; logic ga, ge; int lat;
        xfer(1, 16'h00E8, 1'b0, 4'b0010, 32'h0, rd, ga, ge, lat);
        n_cmp++; if (ga !== 1'b1 || lat != 4) begin n_bad++; $display("FAIL ws3_latency: got ack=%b lat=%0d expected ack=1 lat=4", ga, lat); end
        n_cmp++; if (rd !== 32'h0000E900) begin n_bad++; $display("FAIL e9_signature: got %h expected 0000e900", rd); end
    endtask

    task automatic test_overflow();
        logic [31:0] rd; logic ga, ge; int lat; int acks;
        con_ready = 1'b0;
        acks = 0;
        for (int i = 0; i < 17; i++) begin
            xfer(0, 16'h00E8, 1'b1, 4'b0010, {16'h0, 8'(8'h41 + i), 8'h00}, rd, ga, ge, lat);
            if (ga === 1'b1) acks++;
        end
        n_cmp++; if (acks != 17) begin n_bad++; $display("FAIL fifo_push_acks: got %0d expected 17", acks); end
        xfer(0, 16'h00E8, 1'b0, 4'b0100, 32'h0, rd, ga, ge, lat);
        n_cmp++; if (rd !== 32'h00900000) begin n_bad++; $display("FAIL ea_status_full: got %h expected 00900000", rd); end
        n_cmp++; if ({valid[0], ovf[0], cdata[0]} !== 10'h341) begin n_bad++; $display("FAIL fifo_head: got v=%b o=%b d=%h expected v=1 o=1 d=41", valid[0], ovf[0], cdata[0]); end
        xfer(0, 16'h00E8, 1'b1, 4'b0100, 32'h00800000, rd, ga, ge, lat);
        xfer(0, 16'h00E8, 1'b0, 4'b0100, 32'h0, rd, ga, ge, lat);
        n_cmp++; if (rd !== 32'h00100000 || ovf[0] !== 1'b0) begin n_bad++; $display("FAIL ea_clear_ovf: got %h ovf=%b expected 00100000 ovf=0", rd, ovf[0]); end
    endtask

    task automatic test_push_pop_full();
        logic [31:0] rd; logic ga, ge; int lat; logic [7:0] exp_b;
        @(negedge clk);
        @(negedge clk);
        adr = 16'h00E8; we = 1'b1; sel = 4'b0010; dat = 32'h00005200; stb = 1'b1; cyc[0] = 1'b1;
        con_ready = 1'b1;
        @(negedge clk);
        con_ready = 1'b0;
        n_cmp++; if (ack[0] !== 1'b1 || cdata[0] !== 8'h42) begin n_bad++; $display("FAIL full_push_pop: got ack=%b head=%h expected ack=1 head=42", ack[0], cdata[0]); end
        cyc[0] = 1'b0; stb = 1'b0; we = 1'b0;
        xfer(0, 16'h00E8, 1'b0, 4'b0100, 32'h0, rd, ga, ge, lat);
        n_cmp++; if (rd !== 32'h00100000) begin n_bad++; $display("FAIL full_push_pop_count: got %h expected 00100000", rd); end
        con_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_b = (i < 15) ? 8'(8'h42 + i) : 8'h52;
            n_cmp++; if (valid[0] !== 1'b1 || cdata[0] !== exp_b) begin n_bad++; $display("FAIL drain_%0d: got v=%b d=%h expected v=1 d=%h", i, valid[0], cdata[0], exp_b); end
            @(negedge clk);
        end
        n_cmp++; if (valid[0] !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got %b expected 0", valid[0]); end
        xfer(0, 16'h00E8, 1'b1, 4'b0010, 32'h00007700, rd, ga, ge, lat);
        n_cmp++; if (valid[0] !== 1'b1 || cdata[0] !== 8'h77) begin n_bad++; $display("FAIL empty_push: got v=%b d=%h expected v=1 d=77", valid[0], cdata[0]); end
        @(negedge clk);
        n_cmp++; if (valid[0] !== 1'b0) begin n_bad++; $display("FAIL empty_push_pop: got %b expected 0", valid[0]); end
        con_ready = 1'b0;
    endtask

    task automatic test_unmapped();
        logic [31:0] rd; logic ga, ge; int lat;
        xfer(0, 16'h0060, 1'b0, 4'b1111, 32'h0, rd, ga, ge, lat);
        n_cmp++; if ({ga, ge} !== 2'b10 || rd !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL unmapped_ack: got ack=%b err=%b dat=%h expected ack=1 err=0 dat=ffffffff", ga, ge, rd); end
        xfer(1, 16'h0060, 1'b0, 4'b1111, 32'h0, rd, ga, ge, lat);
        n_cmp++; if ({ga, ge} !== 2'b01 || lat != 4) begin n_bad++; $display("FAIL unmapped_err: got ack=%b err=%b lat=%0d expected ack=0 err=1 lat=4", ga, ge, lat); end
        @(negedge clk);
        n_cmp++; if ({ack[1], err[1]} !== 2'b00) begin n_bad++; $display("FAIL unmapped_err_width: got %b expected 00", {ack[1], err[1]}); end
    endtask

    task automatic test_cyc_drop();
        logic [31:0] rd; logic ga, ge; int lat; int seen;
        @(negedge clk);
        adr = 16'h0080; we = 1'b1; sel = 4'b0001; dat = 32'h000000C3; stb = 1'b1; cyc[2] = 1'b1;
        @(posedge clk);
        repeat (2) @(negedge clk);
        cyc[2] = 1'b0; stb = 1'b0; we = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (ack[2] || err[2]) seen++;
        end
        n_cmp++; if (seen != 0 || post[2] !== 8'h00) begin n_bad++; $display("FAIL cyc_drop: got resp=%0d post=%h expected resp=0 post=00", seen, post[2]); end
        xfer(2, 16'h0080, 1'b1, 4'b0001, 32'h000000C3, rd, ga, ge, lat);
        n_cmp++; if (ga !== 1'b1 || lat != 6 || post[2] !== 8'hC3) begin n_bad++; $display("FAIL ws5_write: got ack=%b lat=%0d post=%h expected ack=1 lat=6 post=c3", ga, lat, post[2]); end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        adr = 16'h0080; we = 1'b1; sel = 4'b0001; dat = 32'h00000099; stb = 1'b1; cyc[2] = 1'b1;
        @(posedge clk);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (post !== 24'h0 || {ack, err} !== 6'h0) begin n_bad++; $display("FAIL reset_mid_async: got post=%h resp=%h expected post=000000 resp=00", post, {ack, err}); end
        cyc[2] = 1'b0; stb = 1'b0; we = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (ack[2] || err[2]) seen++;
        end
        n_cmp++; if (seen != 0 || post[2] !== 8'h00) begin n_bad++; $display("FAIL reset_mid_abort: got resp=%0d post=%h expected resp=0 post=00", seen, post[2]); end
    endtask

    initial begin
        test_reset();
        test_post();
        test_wait_read();
        test_overflow();
        test_push_pop_full();
        test_unmapped();
        test_cyc_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
